// File: rtl/xadc_drp_arbiter.sv
// XADC DRP arbiter: shares the dynamic reconfiguration port between end-of-conversion
// capture and software commands. It also holds the six result registers and tracks lost conversions and stuck transactions.
module xadc_drp_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int OVR_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic        eoc,
  input  logic [4:0]  channel,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic        drp_drdy,
  input  logic [15:0] drp_do
);

  typedef enum logic [1:0] {IDLE, AUTO_WAIT, SW_WAIT} state_t;

  localparam int              TMO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       SLOT_NONE = 3'd7;

  // Result slot for an XADC channel; channels without a slot are read and dropped.
  function automatic logic [2:0] chan_slot(input logic [4:0] ch);
    case (ch)
      5'h16:   chan_slot = 3'd0;
      5'h1E:   chan_slot = 3'd1;
      5'h17:   chan_slot = 3'd2;
      5'h1F:   chan_slot = 3'd3;
      5'h00:   chan_slot = 3'd4;
      5'h01:   chan_slot = 3'd5;
      default: chan_slot = SLOT_NONE;
    endcase
  endfunction

  state_t            state;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              auto_pend;
  logic [4:0]        auto_ch;
  logic [4:0]        cur_ch;
  logic              sw_pend;
  logic              cmd_busy;
  logic              cmd_we;
  logic [6:0]        cmd_addr;
  logic [15:0]       cmd_data;
  logic [15:0]       sw_rdata;
  logic              timeout_err;
  logic [OVR_W-1:0]  ovr_cnt;
  logic [15:0]       results [6];

  logic              cmd_wr;
  logic              clr_wr;
  logic              ovr_evt;
  logic              auto_req;
  logic [4:0]        auto_sel;
  logic [2:0]        cap_slot;
  logic              unused_inputs;

  assign cmd_wr   = cs && write && (reg_addr == 5'd8) && !cmd_busy;
  assign clr_wr   = cs && write && (reg_addr == 5'd9);
  assign ovr_evt  = eoc && auto_pend;
  assign auto_req = auto_pend || eoc;
  assign auto_sel = eoc ? channel : auto_ch;
  assign cap_slot = chan_slot(cur_ch);

  assign unused_inputs = &{1'b0, read, wr_data[31:25], wr_data[23]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      auto_pend   <= 1'b0;
      auto_ch     <= '0;
      cur_ch      <= '0;
      sw_pend     <= 1'b0;
      cmd_busy    <= 1'b0;
      cmd_we      <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      sw_rdata    <= '0;
      timeout_err <= 1'b0;
      ovr_cnt     <= '0;
      drp_den     <= 1'b0;
      drp_dwe     <= 1'b0;
      drp_daddr   <= '0;
      drp_di      <= '0;
      // NOTE: the result words are software-visible and must read 0 after reset,
      // so this small array is reset like ordinary flops rather than left as RAM.
      for (int i = 0; i < 6; i++) results[i] <= '0;
    end else begin
      // NOTE: non-blocking throughout; a later assignment in this block deliberately
      // overrides an earlier one (issue clears auto_pend, a timeout beats a clear).
      drp_den <= 1'b0;
      drp_dwe <= 1'b0;

      if (eoc) begin
        auto_pend <= 1'b1;
        auto_ch   <= channel;
      end

      if (ovr_evt) begin
        if (ovr_cnt != '1) ovr_cnt <= ovr_cnt + 1'b1;
      end else if (clr_wr) begin
        ovr_cnt <= '0;
      end

      if (clr_wr) timeout_err <= 1'b0;

      if (cmd_wr) begin
        cmd_busy <= 1'b1;
        sw_pend  <= 1'b1;
        cmd_we   <= wr_data[24];
        cmd_addr <= wr_data[22:16];
        cmd_data <= wr_data[15:0];
      end

      case (state)
        IDLE: begin
          if (auto_req) begin
            drp_den   <= 1'b1;
            drp_daddr <= {2'b00, auto_sel};
            cur_ch    <= auto_sel;
            auto_pend <= 1'b0;
            tmo_cnt   <= '0;
            state     <= AUTO_WAIT;
          end else if (sw_pend) begin
            drp_den   <= 1'b1;
            drp_dwe   <= cmd_we;
            drp_daddr <= cmd_addr;
            drp_di    <= cmd_data;
            sw_pend   <= 1'b0;
            tmo_cnt   <= '0;
            state     <= SW_WAIT;
          end
        end

        AUTO_WAIT: begin
          if (drp_drdy) begin
            for (int i = 0; i < 6; i++) begin
              if (cap_slot == 3'(i)) results[i] <= drp_do;
            end
            state <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        SW_WAIT: begin
          if (drp_drdy) begin
            if (!cmd_we) sw_rdata <= drp_do;
            cmd_busy <= 1'b0;
            state    <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            cmd_busy    <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns rd_data and no latch is inferred.
    rd_data = '0;
    case (reg_addr)
      5'd0: rd_data = {16'h0, results[0]};
      5'd1: rd_data = {16'h0, results[1]};
      5'd2: rd_data = {16'h0, results[2]};
      5'd3: rd_data = {16'h0, results[3]};
      5'd4: rd_data = {16'h0, results[4]};
      5'd5: rd_data = {16'h0, results[5]};
      5'd8: rd_data = {14'h0, timeout_err, cmd_busy, sw_rdata};
      5'd9: rd_data = 32'(ovr_cnt);
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_xadc_drp_arbiter.sv
// Bench for xadc_drp_arbiter: directed scenarios plus randomized traffic, checked against
// a register-level model and a DRP slave model.
module tb_xadc_drp_arbiter;

  localparam int          TMO      = 8;
  localparam int          OW       = 2;
  localparam logic [31:0] OVR_MAX  = 32'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        eoc;
  logic [4:0]  channel;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic        drp_drdy;
  logic [15:0] drp_do;

  always #50 clk = ~clk;

  xadc_drp_arbiter #(.TIMEOUT_CYCLES(TMO), .OVR_W(OW)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data),
    .eoc(eoc), .channel(channel),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
    .drp_drdy(drp_drdy), .drp_do(drp_do)
  );

  int          vectors     = 0;
  int          miscompares = 0;

  // DRP slave model state
  logic [15:0] drp_mem [128];
  int          resp_delay;
  int          resp_cnt;
  int          den_cnt;
  int          drdy_cnt;
  logic [6:0]  last_addr;
  logic        last_we;
  logic [15:0] last_di;
  logic [15:0] pend_do;
  logic        inject    = 1'b0;
  logic [15:0] inject_do = 16'h0;

  // Register-level expectation
  logic [15:0] exp_res [6];
  logic [15:0] exp_sw;
  logic        exp_terr;
  logic        exp_busy;
  logic [31:0] exp_ovr;

  logic [4:0]  chans [10] = '{5'h16, 5'h1E, 5'h17, 5'h1F, 5'h00, 5'h01, 5'h02, 5'h10, 5'h1A, 5'h08};

  function automatic int slot(input logic [4:0] ch);
    case (ch)
      5'h16:   return 0;
      5'h1E:   return 1;
      5'h17:   return 2;
      5'h1F:   return 3;
      5'h00:   return 4;
      5'h01:   return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] reg8_val();
    return {14'h0, exp_terr, exp_busy, exp_sw};
  endfunction

  // DRP slave: answers each den after resp_delay cycles (negative = never).
  initial begin
    drp_drdy  = 1'b0;
    drp_do    = 16'h0;
    resp_cnt  = -1;
    den_cnt   = 0;
    drdy_cnt  = 0;
    last_addr = '0;
    last_we   = 1'b0;
    last_di   = '0;
    pend_do   = '0;
    forever begin
      @(negedge clk);
      drp_drdy = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          drp_drdy = 1'b1;
          drp_do   = pend_do;
          drdy_cnt++;
          resp_cnt = -1;
        end
      end
      if (inject) begin
        drp_drdy = 1'b1;
        drp_do   = inject_do;
        drdy_cnt++;
      end
      if (drp_den === 1'b1) begin
        den_cnt++;
        last_addr = drp_daddr;
        last_we   = drp_dwe;
        last_di   = drp_di;
        pend_do   = drp_dwe ? 16'h0 : drp_mem[drp_daddr];
        if (resp_delay == 0) begin
          drp_drdy = 1'b1;
          drp_do   = pend_do;
          drdy_cnt++;
        end else if (resp_delay > 0) begin
          resp_cnt = resp_delay;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp_v);
    logic [31:0] v;
    reg_addr = a;
    cs       = 1'b1;
    read     = 1'b1;
    #1;
    v    = rd_data;
    cs   = 1'b0;
    read = 1'b0;
    check(tag, v, exp_v);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 6; i++)
      check_reg($sformatf("%s_reg%0d", tag, i), 5'(i), {16'h0, exp_res[i]});
    check_reg({tag, "_reg8"}, 5'd8, reg8_val());
    check_reg({tag, "_reg9"}, 5'd9, exp_ovr);
    check_reg({tag, "_unmapped"}, 5'($urandom_range(10, 31)), 32'h0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = v;
    tick();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic pulse_eoc(input logic [4:0] ch);
    eoc = 1'b1; channel = ch;
    tick();
    eoc = 1'b0;
  endtask

  task automatic wait_drdy(input string tag, input int target);
    int n = 0;
    while (drdy_cnt < target && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(drdy_cnt >= target), 32'd1);
  endtask

  task automatic check_den(input string tag, input logic [6:0] a, input logic we);
    check({tag, "_den"},   32'(drp_den),   32'd1);
    check({tag, "_daddr"}, 32'(drp_daddr), 32'(a));
    check({tag, "_dwe"},   32'(drp_dwe),   32'(we));
  endtask

  initial begin
    #(100 * 20000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          t;
    int          n;
    int          s;
    logic [4:0]  rch;
    logic [6:0]  ra;
    logic [15:0] rv;
    logic        rwe;

    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    reg_addr = '0; wr_data = '0; eoc = 1'b0; channel = '0;
    resp_delay = -1;
    for (int i = 0; i < 128; i++) drp_mem[i] = 16'($urandom);
    for (int i = 0; i < 6; i++) exp_res[i] = '0;
    exp_sw = '0; exp_terr = 1'b0; exp_busy = 1'b0; exp_ovr = '0;

    repeat (3) tick();
    check("rst_den",   32'(drp_den),   32'd0);
    check("rst_dwe",   32'(drp_dwe),   32'd0);
    check("rst_daddr", 32'(drp_daddr), 32'd0);
    check("rst_di",    32'(drp_di),    32'd0);
    check_all("rst");
    reset = 1'b0;
    tick();

    // Auto capture of aux1 with drdy three cycles after den
    drp_mem[7'h1E] = 16'hA5C0;
    resp_delay = 3;
    pulse_eoc(5'h1E);
    check_den("t1", 7'h1E, 1'b0);
    tick();
    check("t1_den_single", 32'(drp_den), 32'd0);
    tick(); tick();
    check_reg("t1_reg1_before_update", 5'd1, 32'h0);
    tick();
    exp_res[1] = 16'hA5C0;
    check_all("t1");

    // Software write, a command ignored while busy, then software read
    resp_delay = 2;
    t = drdy_cnt;
    drp_mem[7'h41] = 16'h1234;
    wr(5'd8, 32'h0141_1234);
    exp_busy = 1'b1;
    check_reg("t2_busy", 5'd8, reg8_val());
    tick();
    check_den("t2", 7'h41, 1'b1);
    check("t2_di", 32'(drp_di), 32'h1234);
    wr(5'd8, 32'h0042_0000);
    n = den_cnt;
    wait_drdy("t2_wait", t + 1);
    exp_busy = 1'b0;
    check_reg("t2_done", 5'd8, reg8_val());
    repeat (3) tick();
    check("t2_busy_cmd_ignored", 32'(den_cnt), 32'(n));
    t = drdy_cnt;
    wr(5'd8, 32'h0041_0000);
    wait_drdy("t2_rd_wait", t + 1);
    exp_sw = 16'h1234;
    check("t2_rd_addr", 32'(last_addr), 32'h41);
    check_reg("t2_rd_result", 5'd8, 32'h0000_1234);

    // Collision: eoc and command in the same IDLE cycle
    drp_mem[7'h00] = 16'($urandom);
    resp_delay = 2;
    t = drdy_cnt;
    n = den_cnt;
    eoc = 1'b1; channel = 5'h00;
    cs = 1'b1; write = 1'b1; reg_addr = 5'd8; wr_data = 32'h0043_0000;
    tick();
    eoc = 1'b0; cs = 1'b0; write = 1'b0;
    check_den("t3_auto_first", 7'h00, 1'b0);
    wait_drdy("t3_wait_auto", t + 1);
    check("t3_one_outstanding", 32'(den_cnt), 32'(n + 1));
    exp_res[4] = drp_mem[7'h00];
    wait_drdy("t3_wait_cmd", t + 2);
    check("t3_cmd_addr", 32'(last_addr), 32'h43);
    exp_sw = drp_mem[7'h43];
    check_all("t3");

    // Overrun with the count saturating; drdy on the final timeout cycle still counts
    resp_delay = -1;
    t = drdy_cnt;
    n = den_cnt;
    pulse_eoc(5'h01);
    check_den("t4", 7'h01, 1'b0);
    pulse_eoc(5'h16);
    pulse_eoc(5'h17);
    exp_ovr = 32'd1;
    check_reg("t4_ovr1", 5'd9, exp_ovr);
    wr(5'd9, 32'h0);
    exp_ovr = 32'd0;
    check_reg("t4_ovr_clear", 5'd9, exp_ovr);
    eoc = 1'b1; channel = 5'h17;
    cs = 1'b1; write = 1'b1; reg_addr = 5'd9; wr_data = 32'h0;
    tick();
    eoc = 1'b0; cs = 1'b0; write = 1'b0;
    exp_ovr = 32'd1;
    check_reg("t4_ovr_beats_clear", 5'd9, exp_ovr);
    for (int i = 0; i < 3; i++) begin
      pulse_eoc(5'h17);
      if (exp_ovr < OVR_MAX) exp_ovr++;
    end
    check_reg("t4_ovr_saturated", 5'd9, exp_ovr);
    check("t4_no_den_while_waiting", 32'(den_cnt), 32'(n + 1));
    resp_delay = 1;
    inject_do = 16'hC0DE;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    exp_res[5] = 16'hC0DE;
    wait_drdy("t4_wait_pending", t + 2);
    check("t4_pending_addr", 32'(last_addr), 32'h17);
    exp_res[2] = drp_mem[7'h17];
    check_all("t4");
    wr(5'd9, 32'h0);
    exp_ovr = 32'd0;
    check_reg("t4_clear_final", 5'd9, exp_ovr);

    // Timeout on a command that never completes
    resp_delay = -1;
    wr(5'd8, 32'h0050_0000);
    tick();
    check_den("t5", 7'h50, 1'b0);
    exp_busy = 1'b1;
    repeat (7) tick();
    check_reg("t5_still_busy", 5'd8, reg8_val());
    tick();
    exp_busy = 1'b0;
    exp_terr = 1'b1;
    check_reg("t5_timed_out", 5'd8, reg8_val());
    resp_delay = 2;
    t = drdy_cnt;
    pulse_eoc(5'h1F);
    check_den("t5_after", 7'h1F, 1'b0);
    wait_drdy("t5_wait_after", t + 1);
    exp_res[3] = drp_mem[7'h1F];
    check_all("t5");
    wr(5'd9, 32'h0);
    exp_terr = 1'b0;
    check_reg("t5_err_clear", 5'd8, reg8_val());

    // Randomized traffic, one transaction at a time
    for (int i = 0; i < 30; i++) begin
      resp_delay = $urandom_range(0, 4);
      t = drdy_cnt;
      if ($urandom_range(0, 1) == 1) begin
        rch = chans[$urandom_range(0, 9)];
        pulse_eoc(rch);
        check_den($sformatf("rnd%0d_auto", i), {2'b00, rch}, 1'b0);
        wait_drdy($sformatf("rnd%0d_auto_wait", i), t + 1);
        s = slot(rch);
        if (s >= 0) begin
          exp_res[s] = drp_mem[{2'b00, rch}];
          check_reg($sformatf("rnd%0d_auto_res", i), 5'(s), {16'h0, exp_res[s]});
        end
      end else begin
        rwe = 1'($urandom);
        ra  = 7'($urandom);
        rv  = 16'($urandom);
        if (rwe) drp_mem[ra] = rv;
        wr(5'd8, {7'h0, rwe, 1'b0, ra, rv});
        wait_drdy($sformatf("rnd%0d_sw_wait", i), t + 1);
        if (!rwe) exp_sw = drp_mem[ra];
        check($sformatf("rnd%0d_sw_addr", i), 32'(last_addr), 32'(ra));
        check($sformatf("rnd%0d_sw_we", i), 32'(last_we), 32'(rwe));
        if (rwe) check($sformatf("rnd%0d_sw_di", i), 32'(last_di), 32'(rv));
        check_reg($sformatf("rnd%0d_sw_reg8", i), 5'd8, reg8_val());
      end
    end
    check_all("rnd");

    // Reset while a software command is outstanding, then a late drdy
    resp_delay = -1;
    wr(5'd8, 32'h0044_0000);
    tick();
    check_den("t6", 7'h44, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_den",   32'(drp_den),   32'd0);
    check("t6_rst_daddr", 32'(drp_daddr), 32'd0);
    check("t6_rst_di",    32'(drp_di),    32'd0);
    inject_do = 16'hBEEF;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_den_quiet%0d", i), 32'(drp_den), 32'd0);
      tick();
    end
    for (int i = 0; i < 6; i++) exp_res[i] = '0;
    exp_sw = '0; exp_terr = 1'b0; exp_busy = 1'b0; exp_ovr = '0;
    check_all("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
